// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer and its legality checker.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } pc_state_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_legal_check.sv
// Combinational fetch-address legality check, also used by the branch unit for early target checks.
// Define PC_SEQ_ALIGN_CHECK_EN to additionally reject addresses with nonzero bits [1:0].
module pc_legal_check
  import pc_pkg::*;
#(
  parameter int            XLEN       = 64,
  parameter logic [XLEN:0] IMEM_BYTES = (XLEN+1)'(264)
) (
  input  logic [XLEN-1:0] addr,
  output logic            legal
);

  logic [XLEN:0] end_addr;
  logic          in_range;

  // One extra bit so addr + 4 never wraps when IMEM_BYTES sits near 2^XLEN.
  assign end_addr = {1'b0, addr} + (XLEN+1)'(INSTR_BYTES);
  assign in_range = end_addr <= IMEM_BYTES;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign legal = in_range && (addr[1:0] == 2'b00);
`else
  assign legal = in_range;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: stall, redirect, and a sticky fault on illegal next-PC.
// Alignment checking is compiled in when PC_SEQ_ALIGN_CHECK_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN:0]   IMEM_BYTES   = (XLEN+1)'(264)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            fault,
  output logic [XLEN-1:0] fault_addr
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;
  logic [XLEN-1:0] candidate;
  logic            hold;
  logic            candidate_legal;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(INSTR_BYTES);
  assign fetch_valid = (state_q == RUN);
  assign fault       = (state_q == FAULT);
  assign fault_addr  = fault_addr_q;

  // Redirect beats stall: a flush must win over a hazard hold.
  always_comb begin
    candidate = pc_plus4;
    hold      = 1'b0;
    if (redirect_valid) begin
      candidate = redirect_target;
    end else if (stall) begin
      hold = 1'b1;
    end
  end

  pc_legal_check #(
    .XLEN       (XLEN),
    .IMEM_BYTES (IMEM_BYTES)
  ) u_legal (
    .addr  (candidate),
    .legal (candidate_legal)
  );

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    unique case (state_q)
      BOOT: begin
        pc_d    = RESET_VECTOR;
        state_d = RUN;
      end
      RUN: begin
        // A held PC was already legal, so it is not rechecked.
        if (!hold) begin
          if (candidate_legal) begin
            pc_d = candidate;
          end else begin
            fault_addr_d = candidate;
            state_d      = FAULT;
          end
        end
      end
      FAULT: ;
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

endmodule
